// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: memory-control opcodes, MIR field position and FSM states shared with the microsequencer
package mem_ctrl_pkg;
  localparam logic [2:0] MEM_FETCH = 3'b100;
  localparam logic [2:0] MEM_READ  = 3'b010;
  localparam logic [2:0] MEM_WRITE = 3'b001;
  localparam logic [2:0] MEM_NONE  = 3'b000;
  localparam int MIR_W       = 30;
  localparam int MIR_MEM_LSB = 5;
  localparam int MIR_MEM_MSB = 7;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, CAPT} state_t;
  function automatic logic op_legal(input logic [2:0] op);
    return op == MEM_NONE || op == MEM_FETCH || op == MEM_READ || op == MEM_WRITE;
  endfunction
endpackage

// File: rtl/mem_lat_timer.sv
// mem_lat_timer: loadable down-counter; expire flags the decrement that lands on zero
module mem_lat_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= value;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign expire = cnt <= W'(1);
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: executes MIR FETCH/READ/WRITE against the instruction and data memories
module mem_access_unit
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mir_stb,
  input  logic [2:0]        mem_op,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] mar,
  input  logic [DATA_W-1:0] wdata_in,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_rd,
  output logic              dmem_wr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] mbr,
  output logic [7:0]        mbru,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_t     state;
  logic [2:0] op;
  logic       expire;

  mem_lat_timer #(.W(2)) u_timer (
    .clk(clk), .rst(rst), .load(state == REQ), .value(2'(MEM_LAT - 1)), .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op <= MEM_NONE;
      imem_addr <= '0;
      dmem_addr <= '0;
      dmem_wdata <= '0;
      imem_rd <= 1'b0;
      dmem_rd <= 1'b0;
      dmem_wr <= 1'b0;
      mbr <= '0;
      mbru <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      imem_rd <= 1'b0;
      dmem_rd <= 1'b0;
      dmem_wr <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE:
          if (mir_stb) begin
            if (!op_legal(mem_op)) err <= 1'b1;
            else if (mem_op != MEM_NONE) begin
              op <= mem_op;
              busy <= 1'b1;
              state <= REQ;
              if (mem_op == MEM_FETCH) begin
                imem_addr <= pc;
                imem_rd <= 1'b1;
              end else begin
                dmem_addr <= mar;
                dmem_rd <= mem_op == MEM_READ;
                dmem_wr <= mem_op == MEM_WRITE;
                if (mem_op == MEM_WRITE) dmem_wdata <= wdata_in;
              end
            end
          end
        REQ:
          if (op == MEM_WRITE) begin
            done <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end else state <= MEM_LAT == 1 ? CAPT : WAIT;
        WAIT:
          if (expire) state <= CAPT;
        CAPT: begin
          mbr <= op == MEM_FETCH ? imem_rdata : dmem_rdata;
          if (op == MEM_FETCH) mbru <= imem_rdata[DATA_W-1:DATA_W-8];
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // a strobe arriving mid-access is dropped but flagged
      if (mir_stb && state != IDLE) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random accesses checked against a memory-level reference model
module tb_mem_access_unit;
  import mem_ctrl_pkg::*;
  localparam int LAT = 2;

  logic        clk, rst, mir_stb;
  logic [2:0]  mem_op;
  logic [15:0] pc, mar, wdata_in;
  logic [15:0] imem_addr, dmem_addr, dmem_wdata, imem_rdata, dmem_rdata, mbr;
  logic        imem_rd, dmem_rd, dmem_wr, busy, done, err;
  logic [7:0]  mbru;
  logic [15:0] imem_addr1, dmem_addr1, dmem_wdata1, imem_rdata1, dmem_rdata1, mbr1;
  logic        imem_rd1, dmem_rd1, dmem_wr1, busy1, done1, err1;
  logic [7:0]  mbru1;

  logic        bd_we;
  logic [15:0] bd_addr, bd_data;
  logic [15:0] imem [0:65535];
  logic [15:0] dmem [0:65535];
  logic [15:0] model_dmem [0:65535];
  logic [15:0] exp_mbr;
  logic [7:0]  exp_mbru;
  int n_ird, n_drd, n_dwr, n_done, viol;
  int passed = 0, total = 0;

  mem_access_unit #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .mir_stb(mir_stb), .mem_op(mem_op), .pc(pc), .mar(mar),
    .wdata_in(wdata_in), .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .mbr(mbr), .mbru(mbru), .busy(busy), .done(done), .err(err)
  );

  mem_access_unit #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .mir_stb(mir_stb), .mem_op(mem_op), .pc(pc), .mar(mar),
    .wdata_in(wdata_in), .imem_addr(imem_addr1), .imem_rd(imem_rd1), .imem_rdata(imem_rdata1),
    .dmem_addr(dmem_addr1), .dmem_rd(dmem_rd1), .dmem_wr(dmem_wr1), .dmem_wdata(dmem_wdata1),
    .dmem_rdata(dmem_rdata1), .mbr(mbr1), .mbru(mbru1), .busy(busy1), .done(done1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous memories; only the latency-2 unit writes the data memory
  always @(posedge clk) begin
    imem_rdata <= imem[imem_addr];
    dmem_rdata <= dmem[dmem_addr];
    imem_rdata1 <= imem[imem_addr1];
    dmem_rdata1 <= dmem[dmem_addr1];
    if (bd_we) dmem[bd_addr] <= bd_data;
    else if (dmem_wr) dmem[dmem_addr] <= dmem_wdata;
  end

  initial begin
    n_ird = 0; n_drd = 0; n_dwr = 0; n_done = 0; viol = 0;
  end
  always @(posedge clk) begin
    n_ird += int'(imem_rd);
    n_drd += int'(dmem_rd);
    n_dwr += int'(dmem_wr);
    n_done += int'(done);
    if (int'(imem_rd) + int'(dmem_rd) + int'(dmem_wr) > 1) viol++;
    if (int'(imem_rd1) + int'(dmem_rd1) + int'(dmem_wr1) > 1) viol++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
    model_dmem[a] = d;
  endtask

  task automatic do_reset();
    mir_stb = 1'b0; rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_mbr = '0; exp_mbru = '0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] wd, input string tag);
    int i0, d0, w0, lat;
    i0 = n_ird; d0 = n_drd; w0 = n_dwr;
    mir_stb = 1'b1; mem_op = op; wdata_in = wd;
    pc = op == MEM_FETCH ? a : 16'($urandom);
    mar = op == MEM_FETCH ? 16'($urandom) : a;
    tick();
    mir_stb = 1'b0; mem_op = 3'($urandom); pc = 16'($urandom); mar = 16'($urandom);
    chk({tag, "_busy_e0"}, busy, 1);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (done) begin lat = k; break; end
    end
    if (op == MEM_FETCH) begin exp_mbr = imem[a]; exp_mbru = exp_mbr[15:8]; end
    else if (op == MEM_READ) exp_mbr = model_dmem[a];
    else model_dmem[a] = wd;
    chk({tag, "_latency"}, lat, op == MEM_WRITE ? 1 : LAT + 1);
    chk({tag, "_mbr"}, mbr, exp_mbr);
    chk({tag, "_mbru"}, mbru, exp_mbru);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_addr"}, op == MEM_FETCH ? imem_addr : dmem_addr, a);
    if (op == MEM_WRITE) chk({tag, "_wdata"}, dmem_wdata, wd);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_imem_rd_cycles"}, n_ird - i0, op == MEM_FETCH ? 1 : 0);
    chk({tag, "_dmem_rd_cycles"}, n_drd - d0, op == MEM_READ ? 1 : 0);
    chk({tag, "_dmem_wr_cycles"}, n_dwr - w0, op == MEM_WRITE ? 1 : 0);
  endtask

  initial begin
    int w0, i0, d0, dn0;
    logic [2:0] rop;
    rst = 1'b1; mir_stb = 1'b0; mem_op = '0; pc = '0; mar = '0; wdata_in = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    for (int i = 0; i < 256; i++) imem[i] = 16'($urandom);
    imem[16'h0010] = 16'h2A55;
    do_reset();
    chk("rst_mbr", mbr, 0);
    chk("rst_mbru", mbru, 0);
    chk("rst_flags", {busy, done, err, imem_rd, dmem_rd, dmem_wr}, 0);
    chk("rst_addrs", {imem_addr, dmem_addr}, 0);

    poke(16'h0100, 16'h00C8);
    poke(16'h0002, 16'h1234);
    for (int i = 0; i < 16; i++) poke(16'h0200 + 16'(i), 16'($urandom));

    run_op(MEM_FETCH, 16'h0010, 16'h0, "fetch");
    chk("fetch_mbr_const", mbr, 16'h2A55);
    run_op(MEM_READ, 16'h0100, 16'h0, "read");
    chk("read_mbru_kept", mbru, 8'h2A);
    run_op(MEM_WRITE, 16'h0101, 16'h0190, "write");
    chk("write_mem", dmem[16'h0101], 16'h0190);

    for (int i = 0; i < 24; i++) begin
      rop = 3'b100 >> $urandom_range(0, 2);
      run_op(rop, rop == MEM_FETCH ? 16'($urandom_range(0, 255)) : 16'h0200 + 16'($urandom_range(0, 15)),
             16'($urandom), "rand");
    end
    chk("err_clean", err, 0);

    // second strobe arrives while the read is in flight
    w0 = n_dwr;
    mir_stb = 1'b1; mem_op = MEM_READ; mar = 16'h0100;
    tick();
    mem_op = MEM_WRITE; mar = 16'h0105; wdata_in = 16'hBEEF;
    tick();
    mir_stb = 1'b0;
    tick();
    chk("ovl_done_e2", done, 0);
    tick();
    chk("ovl_done_e3", done, 1);
    chk("ovl_mbr", mbr, model_dmem[16'h0100]);
    exp_mbr = model_dmem[16'h0100];
    tick();
    tick();
    chk("ovl_no_write", n_dwr - w0, 0);
    chk("ovl_err", err, 1);
    run_op(MEM_FETCH, 16'h0033, 16'h0, "ovl_fetch");
    chk("ovl_err_sticky", err, 1);

    do_reset();
    chk("rst_err_clear", err, 0);
    i0 = n_ird; d0 = n_drd; w0 = n_dwr; dn0 = n_done;
    mir_stb = 1'b1; mem_op = 3'b110; pc = 16'h0010; mar = 16'h0100;
    tick();
    mir_stb = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("ill_err", err, 1);
    chk("ill_strobes", (n_ird - i0) + (n_drd - d0) + (n_dwr - w0), 0);
    chk("ill_done", n_done - dn0, 0);
    chk("ill_busy", busy, 0);

    do_reset();
    i0 = n_ird; d0 = n_drd; w0 = n_dwr; dn0 = n_done;
    mir_stb = 1'b1; mem_op = MEM_NONE;
    tick();
    mir_stb = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("none_err", err, 0);
    chk("none_strobes", (n_ird - i0) + (n_drd - d0) + (n_dwr - w0), 0);
    chk("none_done", n_done - dn0, 0);

    // reset lands one edge into a read
    run_op(MEM_FETCH, 16'h0010, 16'h0, "pre_rst");
    dn0 = n_done;
    mir_stb = 1'b1; mem_op = MEM_READ; mar = 16'h0100;
    tick();
    mir_stb = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_mbr = '0; exp_mbru = '0;
    chk("mid_rst_strobes", {imem_rd, dmem_rd, dmem_wr}, 0);
    chk("mid_rst_busy_done", {busy, done}, 0);
    chk("mid_rst_mbr", mbr, 0);
    chk("mid_rst_mbru", mbru, 0);
    run_op(MEM_FETCH, 16'h0010, 16'h0, "post_rst_fetch");
    chk("mid_rst_done_count", n_done - dn0, 1);

    mir_stb = 1'b1; mem_op = MEM_READ; mar = 16'h0002;
    tick();
    mir_stb = 1'b0;
    tick();
    chk("lat1_done_e1", done1, 0);
    tick();
    chk("lat1_done_e2", done1, 1);
    chk("lat1_mbr", mbr1, 16'h1234);
    tick();
    chk("lat1_busy", busy1, 0);
    tick();
    tick();

    chk("strobe_onehot", viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
